// File: rtl/xbar_alloc.sv
// ---------------------------------------------------------------------------
// xbar_alloc
//   Switch allocator and sequencer for the 5-port wormhole router crossbar.
//   Each IDLE output runs a round-robin arbitration among the inputs that
//   want it. The winner holds the output from head flit to tail flit. The
//   registered lock state drives the crossbar select word and the per-input
//   transfer strobes.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    [4:0]   input i has a flit at its buffer head
//   req_dest_i     [14:0]  destination of input i at [3i+2:3i], stable per packet
//   req_tail_i     [4:0]   head flit of input i is a tail
//   out_ready_i    [4:0]   output o can take a flit this cycle
//   func_o         [19:0]  crossbar select, field for source s at [4s+3:4s]
//   grant_o        [4:0]   head flit of input i crosses this cycle (buffer pops)
//   out_busy_o     [4:0]   output o is locked to a packet
//   err_o          [4:0]   input i presents an illegal destination this cycle
// ---------------------------------------------------------------------------
module xbar_alloc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  req_valid_i,
    input  logic [14:0] req_dest_i,
    input  logic [4:0]  req_tail_i,
    input  logic [4:0]  out_ready_i,
    output logic [19:0] func_o,
    output logic [4:0]  grant_o,
    output logic [4:0]  out_busy_o,
    output logic [4:0]  err_o
);

    // The func encoding below is written for exactly five ports.
    localparam int NPORTS = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_e;

    // Per-output state: lock state, owning input, last round-robin winner.
    out_state_e  state_q [NPORTS];
    out_state_e  state_d [NPORTS];
    logic [2:0]  owner_q [NPORTS];
    logic [2:0]  owner_d [NPORTS];
    logic [2:0]  rr_q    [NPORTS];
    logic [2:0]  rr_d    [NPORTS];
    // Per-input: set while the input owns an output.
    logic [NPORTS-1:0] in_lock_q;
    logic [NPORTS-1:0] in_lock_d;

    logic [2:0]        dest     [NPORTS];
    logic [NPORTS-1:0] legal;
    logic [NPORTS-1:0] out_xfer;   // locked output moves a flit this cycle
    logic [NPORTS-1:0] out_tail;   // the flit at the owner's head is a tail
    logic              found;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    always_comb begin
        legal = '0;
        err_o = '0;
        for (int i = 0; i < NPORTS; i++) begin
            dest[i]  = req_dest_i[3*i +: 3];
            legal[i] = req_valid_i[i] && (dest[i] <= 3'd4) && (dest[i] != 3'(i));
            err_o[i] = req_valid_i[i] && !legal[i];
        end
    end

    // Flit movement on each locked output, taken from its owner's head.
    always_comb begin
        out_xfer = '0;
        out_tail = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (state_q[o] == LOCKED && owner_q[o] == 3'(i)) begin
                    out_xfer[o] = req_valid_i[i] && out_ready_i[o];
                    out_tail[o] = req_tail_i[i];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    // NOTE: every state array is reset, including owner/rr, because reset
    // must leave the allocator in a known priority order with no stale owner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= 3'd0;
                rr_q[o]    <= 3'd4;   // input 0 is searched first
            end
            in_lock_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values, independent of statement order.
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            in_lock_q <= in_lock_d;
        end
    end

    // ---------------------------------------------------------------
    // Next state: tail release on locked outputs, arbitration on idle ones
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: hold-by-default assignments up front so no path through the
        // loops leaves a target unassigned and infers a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        in_lock_d = in_lock_q;
        found     = 1'b0;
        for (int o = 0; o < NPORTS; o++) begin
            if (state_q[o] == LOCKED) begin
                if (out_xfer[o] && out_tail[o]) begin
                    state_d[o] = IDLE;
                    for (int i = 0; i < NPORTS; i++) begin
                        if (owner_q[o] == 3'(i)) begin
                            in_lock_d[i] = 1'b0;
                        end
                    end
                end
            end else begin
                // Search rr+1, rr+2, ... (mod 5); first eligible input wins.
                // An output freed by a tail this cycle is still LOCKED here,
                // so it cannot re-arbitrate until the next cycle.
                found = 1'b0;
                for (int k = 1; k <= NPORTS; k++) begin
                    for (int i = 0; i < NPORTS; i++) begin
                        if (!found && legal[i] && dest[i] == 3'(o) && !in_lock_q[i]
                            && ((int'(rr_q[o]) + k) % NPORTS) == i) begin
                            found        = 1'b1;
                            state_d[o]   = LOCKED;
                            owner_d[o]   = 3'(i);
                            rr_d[o]      = 3'(i);
                            in_lock_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs, from registered lock state plus current handshake inputs
    // ---------------------------------------------------------------
    always_comb begin
        func_o     = '0;
        grant_o    = '0;
        out_busy_o = '0;
        for (int o = 0; o < NPORTS; o++) begin
            out_busy_o[o] = (state_q[o] == LOCKED);
            for (int s = 0; s < NPORTS; s++) begin
                if (state_q[o] == LOCKED && owner_q[o] == 3'(s)) begin
                    // Source 4 and destinations 0..3 use bit d; a source s<4
                    // going to port 4 reuses its own (otherwise unused) bit s.
                    func_o[4*s + ((s == 4) ? o : ((o < 4) ? o : s))] = 1'b1;
                    if (out_xfer[o]) begin
                        grant_o[s] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_alloc.sv
// ---------------------------------------------------------------------------
// tb_xbar_alloc
//   Directed bench for xbar_alloc. Inputs change 1 time unit after the rising
//   edge; outputs are sampled on the falling edge. Expected values are
//   hand-derived from the allocator's behaviour.
// ---------------------------------------------------------------------------
module tb_xbar_alloc;

    logic        clk;
    logic        rst;
    logic [4:0]  req_valid;
    logic [14:0] req_dest;
    logic [4:0]  req_tail;
    logic [4:0]  out_ready;
    logic [19:0] func;
    logic [4:0]  grant;
    logic [4:0]  out_busy;
    logic [4:0]  err;

    int n_checks = 0;
    int n_pass   = 0;

    xbar_alloc dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_dest_i  (req_dest),
        .req_tail_i  (req_tail),
        .out_ready_i (out_ready),
        .func_o      (func),
        .grant_o     (grant),
        .out_busy_o  (out_busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int d, input logic tail);
        req_valid[i]       = 1'b1;
        req_dest[3*i +: 3] = 3'(d);
        req_tail[i]        = tail;
    endtask

    // Advance to the next cycle; inputs are then driven just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Grant sequence for the contention test: one winner every other cycle,
    // in round-robin order 0, 1, 3, 0, 1, 3 starting from the reset pointer.
    logic [4:0] cont_exp [12] = '{5'h00, 5'h01, 5'h00, 5'h02, 5'h00, 5'h08,
                                  5'h00, 5'h01, 5'h00, 5'h02, 5'h00, 5'h08};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_dest  = '0;
        req_tail  = '0;
        out_ready = 5'h1F;

        // ---------------- reset / idle ----------------
        sample();
        check("rst_func",  32'(func),     32'h0);
        check("rst_grant", 32'(grant),    32'h0);
        check("rst_busy",  32'(out_busy), 32'h0);
        check("rst_err",   32'(err),      32'h0);
        tick();
        rst = 1'b0;
        sample();
        check("idle_func", 32'(func), 32'h0);

        // ---------------- 3-flit packet, input 2 -> output 0 ----------------
        tick();
        set_req(2, 0, 1'b0);
        sample();
        check("p3_c0_grant", 32'(grant), 32'h00);
        tick();
        sample();
        check("p3_c1_func",  32'(func),     32'h00100);
        check("p3_c1_grant", 32'(grant),    32'h04);
        check("p3_c1_busy",  32'(out_busy), 32'h01);
        tick();
        sample();
        check("p3_c2_grant", 32'(grant), 32'h04);
        tick();
        req_tail[2] = 1'b1;
        sample();
        check("p3_c3_grant", 32'(grant), 32'h04);
        tick();
        req_valid = '0;
        req_tail  = '0;
        sample();
        check("p3_c4_func",  32'(func),     32'h0);
        check("p3_c4_busy",  32'(out_busy), 32'h0);
        check("p3_c4_grant", 32'(grant),    32'h0);

        // ---------------- contention on output 2 ----------------
        tick();
        set_req(0, 2, 1'b1);
        set_req(1, 2, 1'b1);
        set_req(3, 2, 1'b1);
        for (int c = 0; c < 12; c++) begin
            sample();
            check($sformatf("cont_c%0d_grant", c), 32'(grant), 32'(cont_exp[c]));
            tick();
        end
        req_valid = '0;
        req_tail  = '0;
        sample();
        check("cont_end_busy", 32'(out_busy), 32'h0);

        // ---------------- stall: input 4 -> output 1 ----------------
        tick();
        set_req(4, 1, 1'b0);
        sample();
        tick();
        sample();
        check("stall_lock_func",  32'(func),  32'h20000);
        check("stall_lock_grant", 32'(grant), 32'h10);
        for (int c = 0; c < 3; c++) begin
            tick();
            out_ready[1] = 1'b0;
            set_req(2, 1, 1'b1);      // competitor for the held output
            sample();
            check($sformatf("stall_%0d_grant", c), 32'(grant),    32'h00);
            check($sformatf("stall_%0d_func", c),  32'(func),     32'h20000);
            check($sformatf("stall_%0d_busy", c),  32'(out_busy), 32'h02);
        end
        tick();
        out_ready[1] = 1'b1;
        req_tail[4]  = 1'b1;
        sample();
        check("stall_tail_grant", 32'(grant), 32'h10);
        tick();
        req_valid[4] = 1'b0;
        req_tail[4]  = 1'b0;
        sample();
        check("stall_free_busy",  32'(out_busy), 32'h00);
        check("stall_free_grant", 32'(grant),    32'h00);
        tick();
        sample();
        check("stall_next_grant", 32'(grant), 32'h04);
        tick();
        req_valid = '0;
        req_tail  = '0;

        // ---------------- five parallel paths ----------------
        set_req(0, 4, 1'b1);
        set_req(1, 0, 1'b1);
        set_req(2, 3, 1'b1);
        set_req(3, 2, 1'b1);
        set_req(4, 1, 1'b1);
        sample();
        check("par_arb_grant", 32'(grant), 32'h00);
        tick();
        sample();
        // 0->4 bit 0, 1->0 bit 4, 2->3 bit 11, 3->2 bit 14, 4->1 bit 17
        check("par_func",  32'(func),     32'h24811);
        check("par_grant", 32'(grant),    32'h1F);
        check("par_busy",  32'(out_busy), 32'h1F);
        tick();
        req_valid = '0;
        req_tail  = '0;
        sample();
        check("par_end_func", 32'(func),     32'h0);
        check("par_end_busy", 32'(out_busy), 32'h0);

        // ---------------- illegal destinations on input 3 ----------------
        tick();
        set_req(3, 3, 1'b1);
        sample();
        check("ill_self_err",   32'(err),   32'h08);
        check("ill_self_grant", 32'(grant), 32'h00);
        tick();
        set_req(3, 6, 1'b1);
        sample();
        check("ill_range_err",  32'(err),      32'h08);
        check("ill_range_busy", 32'(out_busy), 32'h00);
        tick();
        req_valid = '0;
        req_tail  = '0;
        sample();
        check("ill_end_err",   32'(err),      32'h00);
        check("ill_end_busy",  32'(out_busy), 32'h00);
        check("ill_end_grant", 32'(grant),    32'h00);

        // ---------------- async reset mid-packet: input 1 -> output 4 ----------------
        tick();
        set_req(1, 4, 1'b0);
        sample();
        tick();
        sample();
        check("ar_c1_func",  32'(func),  32'h00020);
        check("ar_c1_grant", 32'(grant), 32'h02);
        tick();
        sample();
        check("ar_c2_grant", 32'(grant), 32'h02);
        #1 rst = 1'b1;
        #1;
        check("ar_rst_func",  32'(func),     32'h0);
        check("ar_rst_grant", 32'(grant),    32'h0);
        check("ar_rst_busy",  32'(out_busy), 32'h0);
        tick();
        rst = 1'b0;
        sample();
        check("ar_rel_grant", 32'(grant), 32'h00);
        tick();
        sample();
        check("ar_re_func",  32'(func),  32'h00020);
        check("ar_re_grant", 32'(grant), 32'h02);
        tick();
        req_tail[1] = 1'b1;
        sample();
        check("ar_tail_grant", 32'(grant), 32'h02);
        tick();
        req_valid = '0;
        req_tail  = '0;
        sample();
        check("ar_end_busy", 32'(out_busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
